// File: rtl/vfd_video.sv
// 640x480@60 scan-out reader: raster timing, VRAM fetch, RGB332 expansion.
// Optional half-brightness odd lines when VFD_VIDEO_SCANLINE_EN is defined.
module vfd_video #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  output logic [18:0] vram_addr,
  output logic        vram_rd,
  input  logic [7:0]  vram_data,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        hs,
  output logic        vs,
  output logic        hblank,
  output logic        vblank,
  output logic        de
);

  localparam logic [9:0]  H_VIS_END  = 10'(H_ACTIVE);
  localparam logic [9:0]  H_SYNC_BEG = 10'(H_ACTIVE + 16);
  localparam logic [9:0]  H_SYNC_END = 10'(H_ACTIVE + 112);
  localparam logic [9:0]  H_LAST     = 10'(H_ACTIVE + 159);
  localparam logic [9:0]  V_VIS_END  = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SYNC_BEG = 10'(V_ACTIVE + 10);
  localparam logic [9:0]  V_SYNC_END = 10'(V_ACTIVE + 12);
  localparam logic [9:0]  V_LAST     = 10'(V_ACTIVE + 44);
  localparam logic [18:0] PIX_LAST   = 19'(H_ACTIVE * V_ACTIVE - 1);

  function automatic logic [7:0] expand3(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  function automatic logic [7:0] expand2(input logic [1:0] c);
    return {c, c, c, c};
  endfunction

  logic [9:0]  hc_r;
  logic [9:0]  vc_r;
  logic [18:0] pix_cnt_r;
  logic        rd_q_r;
  logic [7:0]  cap_r;
  logic        de1_r;
  logic        hs1_r;
  logic        vs1_r;
  logic        hb1_r;
  logic        vb1_r;
`ifdef VFD_VIDEO_SCANLINE_EN
  logic        odd1_r;
`endif

  logic        vis_s;
  logic        hs_s;
  logic        vs_s;
  logic        hb_s;
  logic        vb_s;
  logic        hwrap_s;
  logic        vwrap_s;
  logic [7:0]  pix_s;
  logic [7:0]  r_s;
  logic [7:0]  g_s;
  logic [7:0]  b_s;

  // Stage-0 timing decode and colour expansion of the fetched pixel
  always_comb begin
    hb_s    = (hc_r >= H_VIS_END);
    vb_s    = (vc_r >= V_VIS_END);
    vis_s   = ~hb_s & ~vb_s;
    hs_s    = (hc_r >= H_SYNC_BEG) && (hc_r < H_SYNC_END);
    vs_s    = (vc_r >= V_SYNC_BEG) && (vc_r < V_SYNC_END);
    hwrap_s = (hc_r == H_LAST);
    vwrap_s = (vc_r == V_LAST);
    // data is still on the bus when the next ce lands one clk after capture
    pix_s   = rd_q_r ? vram_data : cap_r;
`ifdef VFD_VIDEO_SCANLINE_EN
    r_s = odd1_r ? (expand3(pix_s[7:5]) >> 1) : expand3(pix_s[7:5]);
    g_s = odd1_r ? (expand3(pix_s[4:2]) >> 1) : expand3(pix_s[4:2]);
    b_s = odd1_r ? (expand2(pix_s[1:0]) >> 1) : expand2(pix_s[1:0]);
`else
    r_s = expand3(pix_s[7:5]);
    g_s = expand3(pix_s[4:2]);
    b_s = expand2(pix_s[1:0]);
`endif
  end

  // Stage 0: horizontal and vertical raster counters
  always_ff @(posedge clk) begin
    if (reset) begin
      hc_r <= 10'd0;
      vc_r <= 10'd0;
    end else if (ce_pix) begin
      if (hwrap_s) begin
        hc_r <= 10'd0;
        vc_r <= vwrap_s ? 10'd0 : vc_r + 10'd1;
      end else begin
        hc_r <= hc_r + 10'd1;
      end
    end
  end

  // Stage 1 fetch: linear pixel address, read strobe and data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      vram_rd   <= 1'b0;
      vram_addr <= 19'd0;
      pix_cnt_r <= 19'd0;
      rd_q_r    <= 1'b0;
      cap_r     <= 8'd0;
    end else begin
      vram_rd <= ce_pix & vis_s;
      rd_q_r  <= vram_rd;
      if (rd_q_r) begin
        cap_r <= vram_data;
      end
      if (ce_pix) begin
        if (vis_s) begin
          vram_addr <= pix_cnt_r;
        end
        if (hwrap_s && vwrap_s) begin
          pix_cnt_r <= 19'd0;
        end else if (vis_s && (pix_cnt_r != PIX_LAST)) begin
          pix_cnt_r <= pix_cnt_r + 19'd1;
        end
      end
    end
  end

  // Stage 1 sync/blank delay matching the fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      de1_r  <= 1'b0;
      hs1_r  <= 1'b0;
      vs1_r  <= 1'b0;
      hb1_r  <= 1'b0;
      vb1_r  <= 1'b0;
`ifdef VFD_VIDEO_SCANLINE_EN
      odd1_r <= 1'b0;
`endif
    end else if (ce_pix) begin
      de1_r  <= vis_s;
      hs1_r  <= hs_s;
      vs1_r  <= vs_s;
      hb1_r  <= hb_s;
      vb1_r  <= vb_s;
`ifdef VFD_VIDEO_SCANLINE_EN
      odd1_r <= vc_r[0];
`endif
    end
  end

  // Stage 2: registered video outputs, colour forced black outside de
  always_ff @(posedge clk) begin
    if (reset) begin
      r      <= 8'd0;
      g      <= 8'd0;
      b      <= 8'd0;
      hs     <= 1'b0;
      vs     <= 1'b0;
      hblank <= 1'b0;
      vblank <= 1'b0;
      de     <= 1'b0;
    end else if (ce_pix) begin
      r      <= de1_r ? r_s : 8'd0;
      g      <= de1_r ? g_s : 8'd0;
      b      <= de1_r ? b_s : 8'd0;
      hs     <= hs1_r;
      vs     <= vs1_r;
      hblank <= hb1_r;
      vblank <= vb1_r;
      de     <= de1_r;
    end
  end

endmodule
